// File: rtl/rx78_kbd_matrix.sv
// rx78_kbd_matrix
//   Turns the hps_io ps2_key event stream and the MiSTer joystick words into
//   the RX-78 keyboard/joystick matrix that the CPU scans. The CPU writes a
//   strobe (column select) and reads back eight active-low row bits.
//
//   Key path: capture (stage 0) -> event register + map decode (stage 1)
//   -> matrix update (stage 2) -> registered rows_n / any_key.
//   One key event per clock is sustained.
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   synchronous, active-high
//   ps2_key  in   [10] toggle per event, [9] pressed, [8] E0 prefix, [7:0] scancode
//   joy1     in   joystick 1: [0]R [1]L [2]D [3]U [4]Fire1 [5]Fire2, active-high
//   joy2     in   joystick 2, same layout
//   clear    in   release every keyboard key (held during cartridge download)
//   io_wr    in   one-cycle strobe register write
//   io_din   in   write data, [3:0] is the strobe value
//   rows_n   out  selected column, active-low
//   any_key  out  OR of all keyboard matrix bits
module rx78_kbd_matrix #(
  parameter int NUM_KCOLS = 9,
  parameter int JOY1_COL  = 9,
  parameter int JOY2_COL  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [31:0] joy1,
  input  logic [31:0] joy2,
  input  logic        clear,
  input  logic        io_wr,
  input  logic [7:0]  io_din,
  output logic [7:0]  rows_n,
  output logic        any_key
);

  localparam logic [3:0] JOY1_SEL = 4'(JOY1_COL);
  localparam logic [3:0] JOY2_SEL = 4'(JOY2_COL);

  // Stage 0: toggle tracking and raw capture of {pressed, ext, code}
  logic       tog_q, tog_d;
  logic       cap_v_q, cap_v_d;
  logic [9:0] cap_q, cap_d;

  // Stage 1: event register laid out as {ext, code, pressed}
  logic       evt_v_q, evt_v_d;
  logic [9:0] evt_q, evt_d;

  logic [7:0] matrix_q [NUM_KCOLS];
  logic [7:0] matrix_d [NUM_KCOLS];

  logic [5:0] joy1_q, joy1_d;
  logic [5:0] joy2_q, joy2_d;
  logic [3:0] strobe_q, strobe_d;
  logic [7:0] rows_n_q, rows_n_d;
  logic       any_key_q, any_key_d;

  logic       dec_hit;
  logic [3:0] dec_col;
  logic [2:0] dec_row;
  logic [7:0] sel_col;

  logic       unused_ok;
  assign unused_ok = ^{joy1[31:6], joy2[31:6], io_din[7:4]};

  always_comb begin
    tog_d   = ps2_key[10];
    cap_v_d = ps2_key[10] ^ tog_q;
    cap_d   = ps2_key[9:0];
    evt_v_d = cap_v_q;
    evt_d   = {cap_q[8], cap_q[7:0], cap_q[9]};
  end

  // Scancode map. E0-prefixed codes are separate keys from their plain
  // counterparts, so the lookup key is {ext, code}.
  always_comb begin
    dec_hit = 1'b1;
    dec_col = 4'd0;
    dec_row = 3'd0;
    case (evt_q[9:1])
      9'h045: {dec_col, dec_row} = {4'd0, 3'd0};  // 0
      9'h016: {dec_col, dec_row} = {4'd0, 3'd1};  // 1
      9'h01E: {dec_col, dec_row} = {4'd0, 3'd2};  // 2
      9'h026: {dec_col, dec_row} = {4'd0, 3'd3};  // 3
      9'h025: {dec_col, dec_row} = {4'd0, 3'd4};  // 4
      9'h02E: {dec_col, dec_row} = {4'd0, 3'd5};  // 5
      9'h036: {dec_col, dec_row} = {4'd0, 3'd6};  // 6
      9'h03D: {dec_col, dec_row} = {4'd0, 3'd7};  // 7
      9'h03E: {dec_col, dec_row} = {4'd1, 3'd0};  // 8
      9'h046: {dec_col, dec_row} = {4'd1, 3'd1};  // 9
      9'h04C: {dec_col, dec_row} = {4'd1, 3'd2};  // ;
      9'h052: {dec_col, dec_row} = {4'd1, 3'd3};  // '
      9'h041: {dec_col, dec_row} = {4'd1, 3'd4};  // ,
      9'h04E: {dec_col, dec_row} = {4'd1, 3'd5};  // -
      9'h049: {dec_col, dec_row} = {4'd1, 3'd6};  // .
      9'h04A: {dec_col, dec_row} = {4'd1, 3'd7};  // /
      9'h00E: {dec_col, dec_row} = {4'd2, 3'd0};  // `
      9'h01C: {dec_col, dec_row} = {4'd2, 3'd1};  // A
      9'h032: {dec_col, dec_row} = {4'd2, 3'd2};  // B
      9'h021: {dec_col, dec_row} = {4'd2, 3'd3};  // C
      9'h023: {dec_col, dec_row} = {4'd2, 3'd4};  // D
      9'h024: {dec_col, dec_row} = {4'd2, 3'd5};  // E
      9'h02B: {dec_col, dec_row} = {4'd2, 3'd6};  // F
      9'h034: {dec_col, dec_row} = {4'd2, 3'd7};  // G
      9'h033: {dec_col, dec_row} = {4'd3, 3'd0};  // H
      9'h043: {dec_col, dec_row} = {4'd3, 3'd1};  // I
      9'h03B: {dec_col, dec_row} = {4'd3, 3'd2};  // J
      9'h042: {dec_col, dec_row} = {4'd3, 3'd3};  // K
      9'h04B: {dec_col, dec_row} = {4'd3, 3'd4};  // L
      9'h03A: {dec_col, dec_row} = {4'd3, 3'd5};  // M
      9'h031: {dec_col, dec_row} = {4'd3, 3'd6};  // N
      9'h044: {dec_col, dec_row} = {4'd3, 3'd7};  // O
      9'h04D: {dec_col, dec_row} = {4'd4, 3'd0};  // P
      9'h015: {dec_col, dec_row} = {4'd4, 3'd1};  // Q
      9'h02D: {dec_col, dec_row} = {4'd4, 3'd2};  // R
      9'h01B: {dec_col, dec_row} = {4'd4, 3'd3};  // S
      9'h02C: {dec_col, dec_row} = {4'd4, 3'd4};  // T
      9'h03C: {dec_col, dec_row} = {4'd4, 3'd5};  // U
      9'h02A: {dec_col, dec_row} = {4'd4, 3'd6};  // V
      9'h01D: {dec_col, dec_row} = {4'd4, 3'd7};  // W
      9'h022: {dec_col, dec_row} = {4'd5, 3'd0};  // X
      9'h035: {dec_col, dec_row} = {4'd5, 3'd1};  // Y
      9'h01A: {dec_col, dec_row} = {4'd5, 3'd2};  // Z
      9'h054: {dec_col, dec_row} = {4'd5, 3'd3};  // [
      9'h05D: {dec_col, dec_row} = {4'd5, 3'd4};  // backslash
      9'h05B: {dec_col, dec_row} = {4'd5, 3'd5};  // ]
      9'h055: {dec_col, dec_row} = {4'd5, 3'd6};  // =
      9'h066: {dec_col, dec_row} = {4'd5, 3'd7};  // Backspace
      9'h005: {dec_col, dec_row} = {4'd6, 3'd0};  // F1
      9'h006: {dec_col, dec_row} = {4'd6, 3'd1};  // F2
      9'h004: {dec_col, dec_row} = {4'd6, 3'd2};  // F3
      9'h00C: {dec_col, dec_row} = {4'd6, 3'd3};  // F4
      9'h003: {dec_col, dec_row} = {4'd6, 3'd4};  // F5
      9'h00D: {dec_col, dec_row} = {4'd6, 3'd5};  // Tab
      9'h076: {dec_col, dec_row} = {4'd6, 3'd6};  // Esc
      9'h029: {dec_col, dec_row} = {4'd6, 3'd7};  // Space
      9'h05A: {dec_col, dec_row} = {4'd7, 3'd0};  // Enter
      9'h16C: {dec_col, dec_row} = {4'd7, 3'd1};  // Home
      9'h174: {dec_col, dec_row} = {4'd7, 3'd2};  // Right
      9'h16B: {dec_col, dec_row} = {4'd7, 3'd3};  // Left
      9'h170: {dec_col, dec_row} = {4'd7, 3'd4};  // Insert
      9'h175: {dec_col, dec_row} = {4'd7, 3'd5};  // Up
      9'h172: {dec_col, dec_row} = {4'd7, 3'd6};  // Down
      9'h171: {dec_col, dec_row} = {4'd7, 3'd7};  // Delete
      9'h012: {dec_col, dec_row} = {4'd8, 3'd0};  // Shift L
      9'h059: {dec_col, dec_row} = {4'd8, 3'd0};  // Shift R, same bit as Shift L
      9'h014: {dec_col, dec_row} = {4'd8, 3'd1};  // Ctrl
      9'h058: {dec_col, dec_row} = {4'd8, 3'd2};  // Caps Lock
      default: dec_hit = 1'b0;
    endcase
  end

  // Clear overrides any update landing in the same cycle; events still in
  // the pipeline are applied normally once clear drops.
  always_comb begin
    matrix_d = matrix_q;
    if (clear) begin
      for (int c = 0; c < NUM_KCOLS; c++) matrix_d[c] = 8'h00;
    end else if (evt_v_q && dec_hit) begin
      for (int c = 0; c < NUM_KCOLS; c++) begin
        if (dec_col == c[3:0]) matrix_d[c][dec_row] = evt_q[0];
      end
    end
  end

  always_comb begin
    joy1_d   = joy1[5:0];
    joy2_d   = joy2[5:0];
    strobe_d = io_wr ? io_din[3:0] : strobe_q;

    sel_col = 8'h00;
    for (int c = 0; c < NUM_KCOLS; c++) begin
      if (strobe_q == c[3:0]) sel_col = matrix_q[c];
    end
    if (strobe_q == JOY1_SEL)      sel_col = {2'b00, joy1_q};
    else if (strobe_q == JOY2_SEL) sel_col = {2'b00, joy2_q};
    rows_n_d = ~sel_col;

    any_key_d = 1'b0;
    for (int c = 0; c < NUM_KCOLS; c++) any_key_d = any_key_d | (|matrix_q[c]);
  end

  // tog_q reloads from the live toggle bit in reset so a toggle that was
  // mid-flight (or simply left high) is not replayed afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      tog_q     <= ps2_key[10];
      cap_v_q   <= 1'b0;
      cap_q     <= '0;
      evt_v_q   <= 1'b0;
      evt_q     <= '0;
      for (int c = 0; c < NUM_KCOLS; c++) matrix_q[c] <= 8'h00;
      joy1_q    <= '0;
      joy2_q    <= '0;
      strobe_q  <= 4'hF;
      rows_n_q  <= 8'hFF;
      any_key_q <= 1'b0;
    end else begin
      tog_q     <= tog_d;
      cap_v_q   <= cap_v_d;
      cap_q     <= cap_d;
      evt_v_q   <= evt_v_d;
      evt_q     <= evt_d;
      for (int c = 0; c < NUM_KCOLS; c++) matrix_q[c] <= matrix_d[c];
      joy1_q    <= joy1_d;
      joy2_q    <= joy2_d;
      strobe_q  <= strobe_d;
      rows_n_q  <= rows_n_d;
      any_key_q <= any_key_d;
    end
  end

  assign rows_n  = rows_n_q;
  assign any_key = any_key_q;

endmodule
